// File: rtl/gate_sweep_checker_if.sv
// Bundles the sweep checker's control, status and gate-DUT stimulus/response signals.
// master is the checker side; slave is the host/bench side that also owns the gate DUT.
interface gate_sweep_checker_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned ERR_W = 8
);
  logic              start;
  logic [2:0]        mode;
  logic [N_IN-1:0]   dut_in;
  logic              dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [N_IN-1:0]   first_err_vec;
  logic              first_err_valid;
  logic              illegal_mode;

  modport master (
    input  start,
    input  mode,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output first_err_vec,
    output first_err_valid,
    output illegal_mode
  );

  modport slave (
    output start,
    output mode,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  first_err_vec,
    input  first_err_valid,
    input  illegal_mode
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep engine: drives every N_IN-bit vector into an external gate and checks
// its output against a golden gate model after LAT cycles of DUT latency.
module gate_sweep_checker #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned LAT   = 0,
  parameter int unsigned ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_sweep_checker_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

  localparam logic [2:0] DrainLast = 3'((LAT > 0) ? (LAT - 1) : 0);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [2:0]        drain_q, drain_d;
  logic [2:0]        mode_q, mode_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [N_IN-1:0]   fev_q, fev_d;
  logic              fevv_q, fevv_d;
  logic              pass_q, pass_d;
  logic              ill_q, ill_d;

  logic              cur_valid;
  logic              cmp_valid;
  logic [N_IN-1:0]   cmp_vec;
  logic              expected;
  logic              mismatch;

  function automatic logic golden(input logic [N_IN-1:0] v, input logic [2:0] m);
    logic r;
    case (m)
      3'b000:  r = &v;
      3'b001:  r = |v;
      3'b010:  r = ~&v;
      3'b011:  r = ~|v;
      3'b100:  r = ^v;
      3'b101:  r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cur_valid = (state_q == StDrive);

  // Delay vector and valid so the compare lines up with the DUT's own latency.
  if (LAT == 0) begin : g_comb
    assign cmp_valid = cur_valid;
    assign cmp_vec   = vec_q;
  end else begin : g_pipe
    logic [LAT-1:0]  pv_q;
    logic [N_IN-1:0] pvec_q [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        pv_q <= '0;
        for (int i = 0; i < int'(LAT); i++) pvec_q[i] <= '0;
      end else begin
        pv_q[0]   <= cur_valid;
        pvec_q[0] <= vec_q;
        for (int i = 1; i < int'(LAT); i++) begin
          pv_q[i]   <= pv_q[i-1];
          pvec_q[i] <= pvec_q[i-1];
        end
      end
    end

    assign cmp_valid = pv_q[LAT-1];
    assign cmp_vec   = pvec_q[LAT-1];
  end

  assign expected = golden(cmp_vec, mode_q);
  assign mismatch = cmp_valid && (bus.dut_out != expected);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fevv_d  = fevv_q;
    pass_d  = pass_q;
    ill_d   = ill_q;

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (!fevv_q) begin
        fevv_d = 1'b1;
        fev_d  = cmp_vec;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          err_d   = '0;
          fev_d   = '0;
          fevv_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
          drain_d = '0;
          if (bus.mode < 3'd6) begin
            mode_d  = bus.mode;
            ill_d   = 1'b0;
            state_d = StDrive;
          end else begin
            ill_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDrive: begin
        if (vec_q == '1) begin
          state_d = (LAT > 0) ? StDrain : StDone;
        end else begin
          vec_d = vec_q + N_IN'(1);
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase

    // Resolve pass on entry to DONE so it already reflects the final compare.
    if (state_d == StDone && state_q != StDone) begin
      pass_d = (err_d == '0) && !ill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      drain_q <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      fev_q   <= '0;
      fevv_q  <= 1'b0;
      pass_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fevv_q  <= fevv_d;
      pass_q  <= pass_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.dut_in          = vec_q;
  assign bus.busy            = (state_q == StDrive) || (state_q == StDrain);
  assign bus.done            = (state_q == StDone);
  assign bus.pass            = pass_q;
  assign bus.err_cnt         = err_q;
  assign bus.first_err_vec   = fev_q;
  assign bus.first_err_valid = fevv_q;
  assign bus.illegal_mode    = ill_q;

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Parametrised, self-checking sweep engine for N-input combinational or registered logic gates.
- On start, drives every input vector 0..2^N_IN-1 into an external gate DUT, one vector per cycle.
- Compares the DUT output against an internal golden model for the selected gate mode, after a configurable DUT latency.
- Reports error count, first failing vector and pass/fail.
- Replaces hand-written per-gate stimulus sequences in the logic-gate study benches with a reusable synthesizable block.

Parameters:
N_IN, 3, number of gate inputs; legal range 1..16.
LAT, 0, DUT output latency in clock cycles; legal range 0..7 (0 = combinational DUT).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a sweep; sampled only in IDLE
mode  input  3  gate under test: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110/111 illegal
dut_in  output  N_IN  stimulus vector to DUT; bit 0 = first gate input
dut_out  input  1  DUT gate output
busy  output  1  high while sweeping or draining
done  output  1  one-cycle completion pulse
pass  output  1  last sweep had zero errors and legal mode; held until next start
err_cnt  output  ERR_W  mismatches in last sweep, saturating at 2^ERR_W-1
first_err_vec  output  N_IN  vector of first mismatch; 0 if none
first_err_valid  output  1  at least one mismatch in last sweep
illegal_mode  output  1  last start used mode 110/111

Behaviour:
Reset (rst=1 at edge), from any state including mid-sweep:
- State goes to IDLE.
- dut_in, busy, done, pass, err_cnt, first_err_vec, first_err_valid and illegal_mode all go to 0.
- Delay pipes are cleared.

States:
- IDLE
  - start=1 with legal mode: latch mode; clear err_cnt, first_err_*, pass, illegal_mode; vector counter=0; go to DRIVE.
  - start=1 with illegal mode: go to DONE with illegal_mode=1; no vectors driven.
- DRIVE
  - dut_in = vector counter; counter increments each cycle.
  - After the vector 2^N_IN-1 cycle, go to DRAIN if LAT>0, else DONE.
- DRAIN: exactly LAT cycles with dut_in held at 2^N_IN-1, then go to DONE.
- DONE: one cycle; done=1, busy=0; pass = (err_cnt==0 && !illegal_mode); return to IDLE.

Timing and interface rules:
- busy=1 in DRIVE and DRAIN only, i.e. exactly 2^N_IN+LAT cycles after the start edge. done follows on the next cycle.
- Mode and latency are fixed for the whole sweep; changes to mode mid-sweep are ignored.
- start while busy or in DONE is ignored; no queuing.
- start held high continuously re-triggers on each return to IDLE (one idle cycle between sweeps).

Comparison pipeline:
- Vector and compare-valid are delayed through an LAT-deep shift pipe.
- Expected value is computed from the delayed vector with the latched mode.
- dut_out is sampled in the same cycle the delayed compare-valid is high; LAT=0 compares in the drive cycle itself.
- Each mismatch increments err_cnt; the counter saturates and does not wrap.
- On the first mismatch only: capture first_err_vec and set first_err_valid.
- Golden model: XOR/XNOR are reduction parity over all N_IN bits; N_IN=1 degenerates to buffer/inverter per mode.

Test Plan:
- N_IN=3, LAT=0, mode=011, DUT=correct 3-in NOR, start pulse → dut_in 0..7 on 8 consecutive busy cycles, done next cycle, pass=1, err_cnt=0, first_err_valid=0.
- N_IN=3, LAT=0, dut_out stuck-at-0: mode=011 → err_cnt=1, first_err_vec=0; mode=010 (NAND) → err_cnt=7, first_err_vec=0, pass=0.
- N_IN=3, LAT=2, DUT = NOR registered through 2 flops, mode=011 → busy exactly 10 cycles, pass=1; same DUT with LAT=1 configured → err_cnt nonzero, pass=0.
- N_IN=3, ERR_W=2, mode=100 (XOR), DUT=XNOR → 8 mismatches, err_cnt saturates at 3, first_err_vec=0, first_err_valid=1.
- Mid-sweep rst at dut_in=4 → next cycle busy=0, dut_in=0, err_cnt=0, no done pulse; new start → full 8-vector sweep. start pulses during busy → no restart, sweep completes normally.
- mode=110 with start → busy never asserts, done pulses the following cycle, illegal_mode=1, pass=0, err_cnt=0.
